// File: rtl/aes_inv_cipher_core.sv
// Iterative AES-128 inverse cipher: forward key expansion to rk10, then one decryption round per clock.
// Optional build macro AES_DEC_KEY_CACHE_EN keeps rk10 for the last key so a repeated key skips KEYEXP.
module aes_inv_cipher_core (
  input  logic         AES_clk,
  input  logic         AES_rst,
  input  logic         AES_en,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic [127:0] AES_data_out,
  output logic         AES_data_out_valid,
  output logic         AES_busy
);

  typedef enum logic [2:0] {IDLE, KEYEXP, INIT_ARK, ROUND, FINAL} state_t;

  state_t       r_fsm, w_fsm_nxt;
  logic         r_en_q;
  logic [3:0]   r_cnt;
  logic [127:0] r_state;
  logic [127:0] r_key;
  logic         w_start;
  logic         w_hit;
  logic [127:0] w_isb, w_ark, w_imc;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box needs).
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq, r;
    sq = a;
    r  = 8'h01;
    for (int unsigned k = 1; k < 8; k++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return ginv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0]  ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Undo one expansion step: w[i-4] = w[i] ^ f(w[i-1]) recovered word by word.
  function automatic logic [127:0] key_bwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[31:0]  ^ k[63:32];
    p2 = k[63:32] ^ k[95:64];
    p1 = k[95:64] ^ k[127:96];
    p0 = k[127:96] ^ sub_rot(p3) ^ {rc, 24'h0};
    return {p0, p1, p2, p3};
  endfunction

  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[127-8*(c*4+r) -: 8] = inv_sbox(s[127-8*(((c+4-r)%4)*4+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  assign w_start  = AES_en & ~r_en_q & (r_fsm == IDLE);
  assign w_isb    = inv_shift_sub(r_state);
  assign w_ark    = w_isb ^ r_key;
  assign w_imc    = inv_mix(w_ark);
  assign AES_busy = (r_fsm != IDLE);

`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] r_cache_key, r_cache_rk10;
  logic         r_cache_vld;
  assign w_hit = r_cache_vld & (AES_key_in == r_cache_key);

  // Cached key is recorded at capture and only marked valid once its rk10 exists.
  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      r_cache_key  <= '0;
      r_cache_rk10 <= '0;
      r_cache_vld  <= 1'b0;
    end else if (w_start && !w_hit) begin
      r_cache_key <= AES_key_in;
      r_cache_vld <= 1'b0;
    end else if (r_fsm == KEYEXP && r_cnt == 4'd9) begin
      r_cache_rk10 <= key_fwd(r_key, rcon(r_cnt + 4'd1));
      r_cache_vld  <= 1'b1;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) r_fsm <= IDLE;
    else         r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      IDLE:     if (w_start) w_fsm_nxt = w_hit ? INIT_ARK : KEYEXP;
      KEYEXP:   if (r_cnt == 4'd9) w_fsm_nxt = INIT_ARK;
      INIT_ARK: w_fsm_nxt = ROUND;
      ROUND:    if (r_cnt == 4'd1) w_fsm_nxt = FINAL;
      FINAL:    w_fsm_nxt = IDLE;
      default:  w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      r_en_q             <= 1'b0;
      r_cnt              <= '0;
      r_state            <= '0;
      r_key              <= '0;
      AES_data_out       <= '0;
      AES_data_out_valid <= 1'b0;
    end else begin
      r_en_q             <= AES_en;
      AES_data_out_valid <= 1'b0;
      case (r_fsm)
        IDLE: if (w_start) begin
          r_state <= AES_data_in;
          r_cnt   <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
          r_key   <= w_hit ? r_cache_rk10 : AES_key_in;
`else
          r_key   <= AES_key_in;
`endif
        end
        KEYEXP: begin
          r_key <= key_fwd(r_key, rcon(r_cnt + 4'd1));
          r_cnt <= r_cnt + 4'd1;
        end
        INIT_ARK: begin
          r_state <= r_state ^ r_key;
          r_key   <= key_bwd(r_key, rcon(4'd10));
          r_cnt   <= 4'd9;
        end
        ROUND: begin
          r_state <= w_imc;
          r_key   <= key_bwd(r_key, rcon(r_cnt));
          r_cnt   <= r_cnt - 4'd1;
        end
        FINAL: begin
          AES_data_out       <= w_ark;
          AES_data_out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// Directed-vector bench for aes_inv_cipher_core (FIPS-197 App. B and C.1 vectors).
module tb_aes_inv_cipher_core;

  logic         AES_clk;
  logic         AES_rst;
  logic         AES_en;
  logic [127:0] AES_data_in;
  logic [127:0] AES_key_in;
  logic [127:0] AES_data_out;
  logic         AES_data_out_valid;
  logic         AES_busy;

  int unsigned checks;
  int unsigned failures;

  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;

`ifdef AES_DEC_KEY_CACHE_EN
  localparam int unsigned HIT_LAT = 11;
`else
  localparam int unsigned HIT_LAT = 21;
`endif

  aes_inv_cipher_core dut (
    .AES_clk            (AES_clk),
    .AES_rst            (AES_rst),
    .AES_en             (AES_en),
    .AES_data_in        (AES_data_in),
    .AES_key_in         (AES_key_in),
    .AES_data_out       (AES_data_out),
    .AES_data_out_valid (AES_data_out_valid),
    .AES_busy           (AES_busy)
  );

  initial AES_clk = 1'b0;
  always #5 AES_clk = ~AES_clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called 1 time unit after an edge; returns 1 time unit after the valid edge.
  task automatic do_op(input string tag, input logic [127:0] d, input logic [127:0] k,
                       input logic [127:0] exp, input int unsigned lat, output time t_valid);
    int unsigned n;
    logic        seen;
    AES_data_in = d;
    AES_key_in  = k;
    AES_en      = 1'b1;
    @(posedge AES_clk); #1;
    AES_en = 1'b0;
    check({tag, "_busy_cap"}, 128'(AES_busy), 128'd1);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge AES_clk); #1;
      n++;
      if (AES_data_out_valid) seen = 1'b1;
    end
    t_valid = $time;
    check({tag, "_valid_seen"}, 128'(seen), 128'd1);
    check({tag, "_latency"}, 128'(n), 128'(lat));
    check({tag, "_result"}, AES_data_out, exp);
    check({tag, "_busy_done"}, 128'(AES_busy), 128'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    time t1, t2, t3;
    int unsigned vcnt;
    checks   = 0;
    failures = 0;
    AES_rst     = 1'b1;
    AES_en      = 1'b0;
    AES_data_in = '0;
    AES_key_in  = '0;
    repeat (3) @(posedge AES_clk);
    @(negedge AES_clk) AES_rst = 1'b0;

    repeat (20) @(posedge AES_clk);
    #1;
    check("rst_data_out", AES_data_out, 128'd0);
    check("rst_valid", 128'(AES_data_out_valid), 128'd0);
    check("rst_busy", 128'(AES_busy), 128'd0);

    do_op("appB", B_CT, B_KEY, B_PT, 21, t1);
    @(posedge AES_clk); #1;
    check("appB_valid_pulse", 128'(AES_data_out_valid), 128'd0);
    check("appB_hold", AES_data_out, B_PT);

    do_op("appC", C_CT, C_KEY, C_PT, 21, t1);

    // Input isolation: AES_en held high, data_in changed mid-operation.
    @(posedge AES_clk); #1;
    AES_data_in = B_CT;
    AES_key_in  = B_KEY;
    AES_en      = 1'b1;
    vcnt        = 0;
    for (int k = 1; k <= 51; k++) begin
      @(posedge AES_clk); #1;
      if (AES_data_out_valid) vcnt++;
      if (k == 16) AES_data_in = 128'hdeadbeef_00000000_11111111_22222222;
      if (k == 18) AES_data_in = '1;
      if (k == 20) AES_data_in = C_CT;
    end
    check("iso_pulses", 128'(vcnt), 128'd1);
    check("iso_result", AES_data_out, B_PT);
    check("iso_no_restart", 128'(AES_busy), 128'd0);
    AES_en = 1'b0;

    // Reset between edges C+7 and C+8.
    @(posedge AES_clk); #1;
    AES_data_in = C_CT;
    AES_key_in  = C_KEY;
    AES_en      = 1'b1;
    @(posedge AES_clk); #1;
    AES_en = 1'b0;
    repeat (7) @(posedge AES_clk);
    #1;
    check("mid_busy", 128'(AES_busy), 128'd1);
    #3 AES_rst = 1'b1;
    #1;
    check("mid_rst_data", AES_data_out, 128'd0);
    check("mid_rst_busy", 128'(AES_busy), 128'd0);
    check("mid_rst_valid", 128'(AES_data_out_valid), 128'd0);
    @(negedge AES_clk) AES_rst = 1'b0;
    vcnt = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge AES_clk); #1;
      if (AES_data_out_valid) vcnt++;
    end
    check("mid_no_valid", 128'(vcnt), 128'd0);

    // Fresh run after reset, then back-to-back, then a repeated key.
    do_op("postrst_B", B_CT, B_KEY, B_PT, 21, t1);
    do_op("b2b_C", C_CT, C_KEY, C_PT, 21, t2);
    check("b2b_spacing", 128'(t2 - t1), 128'd220);
    do_op("repeat_C", C_CT, C_KEY, C_PT, HIT_LAT, t3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
